// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: multi-cycle control sequencer for a 4-register file and ALU.
// Accepts one command at a time. Supported commands are an ALU operation, which
// can be iterated, and clear, increment-by-N or decrement-by-N of one register.
// The block drives only the register-file and ALU control signals and keeps the
// registered zcno flags. The ALU-result-to-register data path lives outside.
//
// Handshake: a command is transferred on a rising edge where CmdValid and
// CmdReady are both high. CmdReady is high only in IDLE and does not depend on
// CmdValid. All Cmd* fields are latched on that edge and ignored at all other
// times, so the producer may change them freely while Busy is high.
module rf_alu_sequencer #(
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdOp,
  input  logic [3:0]       CmdAluFun,
  input  logic [1:0]       CmdSrcA,
  input  logic [1:0]       CmdSrcB,
  input  logic [1:0]       CmdDst,
  input  logic [CNT_W-1:0] CmdCount,
  input  logic             CmdFlagWE,
  output logic [1:0]       OutASel,
  output logic [1:0]       OutBSel,
  output logic [1:0]       RFFunSel,
  output logic [3:0]       RegSel,
  output logic [3:0]       AluFunSel,
  input  logic [3:0]       AluFlags,
  output logic [3:0]       Flags,
  output logic             Busy,
  output logic             Done
);

  // Command opcodes
  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  // Register-file function codes
  localparam logic [1:0] RF_DEC  = 2'b00;
  localparam logic [1:0] RF_INC  = 2'b01;
  localparam logic [1:0] RF_LOAD = 2'b10;
  localparam logic [1:0] RF_CLR  = 2'b11;

  localparam logic [CNT_W-1:0] ITER_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_EXEC  = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t state, state_next;

  // Latched command
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_fun;
  logic [1:0]       cmd_src_a;
  logic [1:0]       cmd_src_b;
  logic [1:0]       cmd_dst;
  logic             cmd_flag_we;
  logic [CNT_W-1:0] iter;
  logic             first_iter;

  logic       accept;
  logic       write_last;
  logic [3:0] dst_wr_mask;
  logic [3:0] reg_sel_dec;

  assign accept      = CmdValid && (state == S_IDLE);
  // A clear is a single write no matter the count. Every other command stops
  // when the remaining count is already zero, so iter never goes below zero.
  assign write_last  = (cmd_op == OP_CLR) || (iter == '0);
  assign dst_wr_mask = ~(4'b0001 << cmd_dst);

  // State register, command latch, iteration counter and flag register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      cmd_op      <= '0;
      cmd_fun     <= '0;
      cmd_src_a   <= '0;
      cmd_src_b   <= '0;
      cmd_dst     <= '0;
      cmd_flag_we <= 1'b0;
      iter        <= '0;
      first_iter  <= 1'b0;
      Flags       <= 4'b0000;
    end else begin
      state <= state_next;
      if (accept) begin
        cmd_op      <= CmdOp;
        cmd_fun     <= CmdAluFun;
        cmd_src_a   <= CmdSrcA;
        cmd_src_b   <= CmdSrcB;
        cmd_dst     <= CmdDst;
        cmd_flag_we <= CmdFlagWE;
        iter        <= CmdCount;
        first_iter  <= 1'b1;
      end else if (state == S_WRITE) begin
        if (!write_last) begin
          iter <= iter - ITER_ONE;
        end
        // After the first write, later ALU iterations feed Dst back into port A
        first_iter <= 1'b0;
        if ((cmd_op == OP_ALU) && cmd_flag_we) begin
          Flags <= AluFlags;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (CmdOp == OP_ALU) ? S_EXEC : S_WRITE;
        end
      end
      S_EXEC: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        if (write_last) begin
          state_next = S_DONE;
        end else if (cmd_op == OP_ALU) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_WRITE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Control outputs decoded from registered state and the latched command only
  always_comb begin
    OutASel     = 2'b00;
    OutBSel     = 2'b00;
    AluFunSel   = 4'h0;
    RFFunSel    = RF_LOAD;
    reg_sel_dec = 4'b1111;
    CmdReady    = 1'b0;
    Busy        = 1'b1;
    Done        = 1'b0;
    case (state)
      S_IDLE: begin
        CmdReady = 1'b1;
        Busy     = 1'b0;
      end
      S_EXEC: begin
        // Settle cycle: operands and function are presented, nothing is written
        OutASel   = first_iter ? cmd_src_a : cmd_dst;
        OutBSel   = cmd_src_b;
        AluFunSel = cmd_fun;
      end
      S_WRITE: begin
        reg_sel_dec = dst_wr_mask;
        case (cmd_op)
          OP_ALU: begin
            OutASel   = first_iter ? cmd_src_a : cmd_dst;
            OutBSel   = cmd_src_b;
            AluFunSel = cmd_fun;
            RFFunSel  = RF_LOAD;
          end
          OP_CLR: begin
            OutASel  = cmd_dst;
            OutBSel  = cmd_dst;
            RFFunSel = RF_CLR;
          end
          OP_INC: begin
            OutASel  = cmd_dst;
            OutBSel  = cmd_dst;
            RFFunSel = RF_INC;
          end
          OP_DEC: begin
            OutASel  = cmd_dst;
            OutBSel  = cmd_dst;
            RFFunSel = RF_DEC;
          end
          default: begin
            reg_sel_dec = 4'b1111;
          end
        endcase
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
        reg_sel_dec = 4'b1111;
      end
    endcase
  end

  // Reset masks every write enable immediately, including in the middle of a command
  assign RegSel = Reset ? 4'b1111 : reg_sel_dec;

endmodule
